// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit:
// operation codes and the control FSM states.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
// Sign-magnitude core: one shift-add or restoring-divide step per cycle, signs fixed up at the end.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W  = WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             bzero_q, bzero_d;
    logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             op_valid, op_signed;
    logic [W-1:0]     a_mag, b_mag;
    logic [W:0]       mul_sum, div_r, div_diff;
    logic [2*W-1:0]   mul_next, div_next, prod_fix;
    logic [W-1:0]     quo_fix, rem_fix;

    always_comb begin
        op_valid  = (op <= MDU_MTLO);
        op_signed = (op == MDU_MULT) || (op == MDU_DIV);
        a_mag     = (op_signed && a[W-1]) ? -a : a;
        b_mag     = (op_signed && b[W-1]) ? -b : b;

        // Multiply: acc = {partial product, remaining multiplier bits}
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = {mul_sum, acc_q[W-1:1]};

        // Divide: acc = {remainder, dividend bits shifting into quotient}
        div_r     = acc_q[2*W-1:W-1];
        div_diff  = div_r - {1'b0, mcand_q};
        div_next  = div_diff[W] ? {div_r[W-1:0], acc_q[W-2:0], 1'b0}
                                : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};

        prod_fix  = neg_lo_q ? -acc_q : acc_q;
        quo_fix   = neg_lo_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix   = neg_hi_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        bzero_d  = bzero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start && op_valid) begin
                    dbz_d = 1'b0;
                    if (op == MDU_MTHI) begin
                        hi_d   = a;
                        done_d = 1'b1;
                    end else if (op == MDU_MTLO) begin
                        lo_d   = a;
                        done_d = 1'b1;
                    end else begin
                        is_div_d = op[1];
                        neg_lo_d = op_signed && (a[W-1] ^ b[W-1]);
                        neg_hi_d = op_signed && a[W-1];
                        bzero_d  = (b == '0);
                        mcand_d  = op[1] ? b_mag : a_mag;
                        acc_d    = {{W{1'b0}}, (op[1] ? a_mag : b_mag)};
                        cnt_d    = '0;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else begin
                    // With a zero divisor the remainder path reproduces the dividend unchanged
                    hi_d  = rem_fix;
                    lo_d  = bzero_q ? '1 : quo_fix;
                    dbz_d = bzero_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            bzero_q  <= bzero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: cycle-level reference model checked every cycle,
// directed literal cases plus randomized operation streams.
module tb_mdu_iterative;
    import mdu_pkg::*;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    mdu_iterative #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, straight from integer arithmetic.
    function automatic void ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] rh, output logic [31:0] rl, output logic rz);
        longint sx, sy, q, r;
        logic [63:0] p;
        rz = 1'b0;
        rh = '0;
        rl = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == MDU_MULT) begin
            p = sx * sy;
            rh = p[63:32];
            rl = p[31:0];
        end else if (o == MDU_MULTU) begin
            p = {32'b0, x} * {32'b0, y};
            rh = p[63:32];
            rl = p[31:0];
        end else if (y == 0) begin
            rh = x;
            rl = '1;
            rz = 1'b1;
        end else begin
            if (o == MDU_DIV) begin
                q = sx / sy;
                r = sx % sy;
            end else begin
                q = longint'({32'b0, x}) / longint'({32'b0, y});
                r = longint'({32'b0, x}) % longint'({32'b0, y});
            end
            rh = r[31:0];
            rl = q[31:0];
        end
    endfunction

    // Reference model: a countdown to the write-back edge plus pending results.
    int          m_cnt;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_dbz, p_dbz, m_done;

    always @(posedge clk) begin : model
        logic [31:0] th, tl;
        logic tz;
        if (rst) begin
            m_cnt  <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_dbz  <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_dbz  <= p_dbz;
                    m_done <= 1'b1;
                end
            end else if (start && op <= MDU_MTLO) begin
                m_dbz <= 1'b0;
                if (op == MDU_MTHI) begin
                    m_hi   <= a;
                    m_done <= 1'b1;
                end else if (op == MDU_MTLO) begin
                    m_lo   <= a;
                    m_done <= 1'b1;
                end else begin
                    ref_op(op, a, b, th, tl, tz);
                    p_hi  <= th;
                    p_lo  <= tl;
                    p_dbz <= tz;
                    m_cnt <= LAT;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 64'(busy), 64'(m_cnt != 0));
            chk("done", 64'(done), 64'(m_done));
            chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    // Called at a falling edge; request is accepted at the next rising edge.
    task automatic go(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_done(output int nbusy);
        int n;
        n = 0;
        nbusy = 0;
        while (!done && n < 200) begin
            if (busy) nbusy++;
            n++;
            @(negedge clk);
        end
        if (!done) chk("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_lit(input string name, input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        int nb;
        go(o, x, y);
        wait_done(nb);
        chk({name, "_hi"}, 64'(hi), 64'(eh));
        chk({name, "_lo"}, 64'(lo), 64'(el));
    endtask

    initial begin
        int nb;
        bit seen;
        logic [2:0] ro;
        logic [31:0] ra, rb;

        rst = 1'b1;
        start = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_dbz", 64'(div_by_zero), 64'(0));
        rst = 1'b0;
        cmp_en = 1'b1;

        // Signed multiply, latency and one-cycle done
        go(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(nb);
        chk("mult_busy_cycles", 64'(nb), 64'(LAT));
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));

        run_lit("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_lit("mult_m1", MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
        run_lit("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_lit("div_min", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        run_lit("divu_zero", MDU_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        chk("dbz_set", 64'(div_by_zero), 64'(1));
        go(MDU_MULTU, 32'd3, 32'd4);
        chk("dbz_clear_at_accept", 64'(div_by_zero), 64'(0));
        wait_done(nb);
        chk("multu_small_lo", 64'(lo), 64'd12);

        // Second start while busy must be dropped
        go(MDU_MULT, 32'd6, 32'd7);
        repeat (3) @(negedge clk);
        go(MDU_DIV, 32'd100, 32'd3);
        wait_done(nb);
        chk("ignored_hi", 64'(hi), 64'd0);
        chk("ignored_lo", 64'(lo), 64'd42);

        // Reset mid-operation aborts without done
        go(MDU_DIV, 32'd1000, 32'd9);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_hi", 64'(hi), 64'(0));
        chk("abort_lo", 64'(lo), 64'(0));
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'(0));

        // MTHI: immediate write, done next cycle, never busy
        go(MDU_MTHI, 32'h1234, 32'h0);
        chk("mthi_hi", 64'(hi), 64'h1234);
        chk("mthi_done", 64'(done), 64'(1));
        chk("mthi_busy", 64'(busy), 64'(0));
        @(negedge clk);

        // Back-to-back start issued in the done cycle
        go(MDU_MULT, 32'd2, 32'd3);
        wait_done(nb);
        run_lit("b2b_divu", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        // Reserved op is ignored
        go(3'b110, 32'hDEAD, 32'hBEEF);
        chk("reserved_busy", 64'(busy), 64'(0));
        chk("reserved_done", 64'(done), 64'(0));

        // Randomized stream, checked every cycle by the model
        for (int i = 0; i < 70; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            go(ro, ra, rb);
            if (ro <= MDU_MTLO) wait_done(nb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_iterative.md
# mdu_iterative

Parametrised iterative multiply/divide unit for the MIPS datapath; the multi-cycle companion to the single-cycle ALU. It executes MULT/MULTU/DIV/DIVU with a start/busy/done handshake, holds results in architectural HI/LO registers, and supports MTHI/MTLO. It sits beside the ALU in EX; control stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32, operand and HI/LO width (≥4, even)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only while `busy`=0
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
- `a`  in  WIDTH  multiplicand / dividend / MTxx source
- `b`  in  WIDTH  multiplier / divisor
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse: HI/LO just updated
- `div_by_zero`  out  1  last DIV/DIVU had b=0; valid from `done` until next accepted start
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- States: IDLE, CALC, FIX.
- IDLE, `start`=1, op ∈ {MULT..DIVU}: latch op, magnitudes |a|,|b| (signed ops) or raw a,b (unsigned), result signs; count←0; → CALC.
- IDLE, `start`=1, MTHI/MTLO: hi (resp. lo)←a at that edge; `done` pulses next cycle; stay IDLE; `busy` never rises.
- Reserved op: start ignored, no state change.
- CALC: one iteration per cycle, exactly WIDTH cycles. Multiply: shift-add over 2·WIDTH accumulator. Divide: restoring, one quotient bit per cycle. After count=WIDTH−1 → FIX.
- FIX: apply signs; write hi/lo; assert `done`; → IDLE.
  - MULT/MULTU: {hi,lo} = 2·WIDTH-bit product; negate full product if signs differ.
  - DIV/DIVU: lo=quotient, hi=remainder; quotient negated if signs differ, remainder takes dividend sign (truncating division).
  - Signed MIN/−1: lo=MIN (wraps), hi=0.
  - b=0: hi=a, lo=all ones, `div_by_zero`=1; full latency still taken.
- `start` while `busy`=1: ignored, no queuing.
- HI/LO hold value between operations; only FIX or MTHI/MTLO write them.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, `div_by_zero`=0, hi=0, lo=0. Reset mid-operation aborts, no `done`.
- Start accepted at edge E0. `busy`=1 for WIDTH+1 cycles (after E0 until edge E0+WIDTH+1).
- At edge E0+WIDTH+1: hi/lo/`div_by_zero` updated, `done`=1, `busy`=0 in same cycle.
- New `start` is legal in the `done` cycle (back-to-back, no bubble).
- MTHI/MTLO: register visible after E0; `done` high in cycle after E0.
- Operands a/b/op need only be valid at E0.

## Structure
- Package `mdu_pkg`: op encodings (`MDU_MULT`…`MDU_MTLO`), state enum (IDLE/CALC/FIX).
- Single module; iteration counter width $clog2(WIDTH). No sub-module required.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=7 → after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFEB, `done` one cycle, `busy` high exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; MULT same operands → hi=0, lo=1.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=5, b=0 → hi=5, lo=0xFFFFFFFF, `div_by_zero`=1; following MULTU clears it at accept.
- MULT started, second `start` (DIV) at cycle 5 → ignored, MULT result only; `rst` at cycle 10 of another op → busy=0, hi=lo=0, no `done`.
- MTHI a=0x1234 → hi=0x1234 next cycle, `done` pulse, `busy` stays 0; start DIVU 100/7 in `done` cycle of prior op → lo=14, hi=2.
